// File: rtl/reset_seq_pkg.sv
// Shared types and sizing helpers for the SoC reset sequencer.
package reset_seq_pkg;

  typedef enum logic [1:0] {
    HOLD    = 2'd0,
    STRETCH = 2'd1,
    RELEASE = 2'd2,
    RUN     = 2'd3
  } seq_state_e;

  typedef enum logic [1:0] {
    CAUSE_POR = 2'd0,
    CAUSE_BTN = 2'd1,
    CAUSE_PLL = 2'd2,
    CAUSE_SW  = 2'd3
  } cause_e;

  // Width of a counter that must reach the largest of the three cycle targets.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    m = (m > c) ? m : c;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/reset_sequencer_debounce.sv
// Level debouncer: the output follows the input only after CYCLES
// consecutive cycles of disagreement; any agreeing cycle restarts the count.
module debounce_filter
  import reset_seq_pkg::*;
#(
  parameter int CYCLES = 65535
) (
  input  logic clk,
  input  logic resetn,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(CYCLES - 1);

  logic [CW-1:0] cnt_reg;
  logic          dout_reg;

  // Resting level is "released" so a held button at power-up still needs a full debounce.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_reg  <= '0;
      dout_reg <= 1'b1;
    end else if (din == dout_reg) begin
      cnt_reg <= '0;
    end else if (cnt_reg == CNT_LAST) begin
      cnt_reg  <= '0;
      dout_reg <= din;
    end else begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign dout = dout_reg;

endmodule

// File: rtl/reset_sequencer.sv
// SoC reset controller: holds all domains in reset until PLLs lock and the
// button is released, stretches, then releases domains one by one in index order.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_DOMAINS     = 4,
  parameter int NUM_LOCKS       = 1,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 65535,
  parameter int STRETCH_CYCLES  = 16,
  parameter int STAGGER_CYCLES  = 8
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   btn_n,
  input  logic [NUM_LOCKS-1:0]   pll_lock,
  input  logic                   sw_rst_req,
  output logic [NUM_DOMAINS-1:0] rst_out,
  output logic                   sys_ready,
  output logic [1:0]             rst_cause
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES, STRETCH_CYCLES, STAGGER_CYCLES);
  localparam int IDX_W = (NUM_DOMAINS > 1) ? $clog2(NUM_DOMAINS) : 1;
  localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
  localparam logic [CNT_W-1:0] STAGGER_LAST = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [IDX_W-1:0] IDX_LAST     = IDX_W'(NUM_DOMAINS - 1);
  // Bit 0 is the button (idles high); the lock bits idle low so we wait for real lock.
  localparam logic [NUM_LOCKS:0] SYNC_INIT  = {{NUM_LOCKS{1'b0}}, 1'b1};

  logic [NUM_LOCKS:0] raw_in;
  logic [NUM_LOCKS:0] sync_in;
  logic               btn_db;
  logic               all_locked;
  logic               abort_evt;

  assign raw_in = {pll_lock, btn_n};

  for (genvar gi = 0; gi <= NUM_LOCKS; gi++) begin : g_sync
    logic [SYNC_STAGES-1:0] chain_reg;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        chain_reg <= {SYNC_STAGES{SYNC_INIT[gi]}};
      end else begin
        chain_reg <= {chain_reg[SYNC_STAGES-2:0], raw_in[gi]};
      end
    end

    assign sync_in[gi] = chain_reg[SYNC_STAGES-1];
  end

  debounce_filter #(
    .CYCLES (DEBOUNCE_CYCLES)
  ) u_btn_debounce (
    .clk    (clk),
    .resetn (resetn),
    .din    (sync_in[0]),
    .dout   (btn_db)
  );

  assign all_locked = &sync_in[NUM_LOCKS:1];
  assign abort_evt  = ~all_locked | ~btn_db | sw_rst_req;

  seq_state_e             state_reg, state_next;
  logic [CNT_W-1:0]       cnt_reg, cnt_next;
  logic [IDX_W-1:0]       idx_reg, idx_next;
  logic [NUM_DOMAINS-1:0] rst_out_reg, rst_next;
  cause_e                 cause_reg, cause_next;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg   <= HOLD;
      cnt_reg     <= '0;
      idx_reg     <= '0;
      rst_out_reg <= '1;
      cause_reg   <= CAUSE_POR;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      idx_reg     <= idx_next;
      rst_out_reg <= rst_next;
      cause_reg   <= cause_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    idx_next   = idx_reg;
    rst_next   = rst_out_reg;
    cause_next = cause_reg;

    unique case (state_reg)
      HOLD: begin
        rst_next = '1;
        cnt_next = '0;
        idx_next = '0;
        if (all_locked && btn_db && !sw_rst_req) begin
          state_next = STRETCH;
        end
      end
      STRETCH: begin
        if (cnt_reg == STRETCH_LAST) begin
          // Domain 0 leaves reset on the very edge that enters RELEASE.
          cnt_next    = '0;
          rst_next[0] = 1'b0;
          idx_next    = IDX_W'(1);
          state_next  = (NUM_DOMAINS == 1) ? RUN : RELEASE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RELEASE: begin
        if (cnt_reg == STAGGER_LAST) begin
          cnt_next          = '0;
          rst_next[idx_reg] = 1'b0;
          if (idx_reg == IDX_LAST) begin
            state_next = RUN;
          end else begin
            idx_next = idx_reg + 1'b1;
          end
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      RUN: begin
        rst_next = '0;
      end
      default: begin
        state_next = HOLD;
        rst_next   = '1;
      end
    endcase

    // Aborts outrank sequencing; PLL loss is the most fundamental cause, software the least.
    if (state_reg != HOLD && abort_evt) begin
      state_next = HOLD;
      rst_next   = '1;
      cnt_next   = '0;
      idx_next   = '0;
      if (!all_locked) begin
        cause_next = CAUSE_PLL;
      end else if (!btn_db) begin
        cause_next = CAUSE_BTN;
      end else begin
        cause_next = CAUSE_SW;
      end
    end
  end

  assign rst_out   = rst_out_reg;
  assign sys_ready = ~|rst_out_reg;
  assign rst_cause = cause_reg;

endmodule

// File: tb/tb_reset_sequencer.sv
// Self-checking bench for reset_sequencer: per-cycle behavioural model plus
// directed scenarios with hand-computed latencies.
module tb_reset_sequencer;

  localparam int N   = 3;
  localparam int NL  = 1;
  localparam int SS  = 2;
  localparam int DEB = 4;
  localparam int STR = 5;
  localparam int STG = 2;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          btn_n = 1'b1;
  logic [NL-1:0] pll_lock = '1;
  logic          sw_rst_req = 1'b0;
  logic [N-1:0]  rst_out;
  logic          sys_ready;
  logic [1:0]    rst_cause;

  always #5 clk = ~clk;

  reset_sequencer #(
    .NUM_DOMAINS     (N),
    .NUM_LOCKS       (NL),
    .SYNC_STAGES     (SS),
    .DEBOUNCE_CYCLES (DEB),
    .STRETCH_CYCLES  (STR),
    .STAGGER_CYCLES  (STG)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .btn_n      (btn_n),
    .pll_lock   (pll_lock),
    .sw_rst_req (sw_rst_req),
    .rst_out    (rst_out),
    .sys_ready  (sys_ready),
    .rst_cause  (rst_cause)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: "hold" plus cycles-since-hold-exit t; outputs follow arithmetically from t.
  int lk_line [SS];
  int bt_line [SS];
  int deb, dcnt, hold, t, m_cause;

  function automatic logic [N-1:0] exp_rst(input int h, input int tt);
    int rel;
    logic [N-1:0] ones;
    ones = '1;
    if (h != 0 || tt < STR) return ones;
    rel = (tt - STR) / STG + 1;
    if (rel > N) rel = N;
    return ones << rel;
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < SS; i++) begin
        lk_line[i] = 0;
        bt_line[i] = 1;
      end
      deb = 1; dcnt = 0; hold = 1; t = 0; m_cause = 0;
    end else begin
      int lk_s, bt_s, old_deb;
      lk_s = lk_line[SS-1];
      bt_s = bt_line[SS-1];
      for (int i = SS - 1; i > 0; i--) begin
        lk_line[i] = lk_line[i-1];
        bt_line[i] = bt_line[i-1];
      end
      lk_line[0] = int'(pll_lock[0]);
      bt_line[0] = int'(btn_n);
      old_deb = deb;
      if (bt_s != deb) begin
        dcnt++;
        if (dcnt == DEB) begin
          deb = bt_s;
          dcnt = 0;
        end
      end else begin
        dcnt = 0;
      end
      if (hold != 0) begin
        if (lk_s != 0 && old_deb != 0 && !sw_rst_req) begin
          hold = 0;
          t = 0;
        end
      end else if (lk_s == 0 || old_deb == 0 || sw_rst_req) begin
        hold = 1;
        m_cause = (lk_s == 0) ? 2 : ((old_deb == 0) ? 1 : 3);
      end else if (t < 1000) begin
        t++;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model rst_out", int'(rst_out), int'(exp_rst(hold, t)));
      check("model sys_ready", int'(sys_ready), int'(exp_rst(hold, t) == '0));
      check("model rst_cause", int'(rst_cause), m_cause);
    end
  end

  // Waits (sampling 1 time unit after each edge) for rst_out==val; the cycle count is pinned.
  task automatic wait_rst(input string name, input logic [N-1:0] val, input int exp_cyc);
    int c;
    c = 0;
    do begin
      @(posedge clk);
      #1;
      c++;
    end while (rst_out !== val && c < exp_cyc + 20);
    if (rst_out !== val) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: rst_out=%b, required %b within %0d cycles", name, rst_out, val, exp_cyc);
    end else begin
      check(name, c, exp_cyc);
    end
    $display("txn %-22s rst_out=%b after %0d cycles ready=%0b cause=%0d",
             name, rst_out, c, sys_ready, rst_cause);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // 1. power-on
    repeat (3) @(posedge clk);
    #1;
    check("reset rst_out", int'(rst_out), 7);
    check("reset sys_ready", int'(sys_ready), 0);
    check("reset rst_cause", int'(rst_cause), 0);
    #1;
    resetn = 1'b1;
    cmp_en = 1'b1;
    wait_rst("por release d0", 3'b110, 8);
    wait_rst("por release d1", 3'b100, 2);
    wait_rst("por release d2", 3'b000, 2);
    check("por sys_ready", int'(sys_ready), 1);
    check("por rst_cause", int'(rst_cause), 0);

    // 2. one-cycle PLL lock drop in RUN
    #1;
    pll_lock = '0;
    @(posedge clk);
    #2;
    pll_lock = '1;
    wait_rst("pll loss", 3'b111, 2);
    check("pll cause", int'(rst_cause), 2);
    wait_rst("pll replay d0", 3'b110, 6);
    wait_rst("pll replay done", 3'b000, 4);

    // 3. short glitch ignored, long press accepted
    #1;
    btn_n = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    btn_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check("glitch rst_out", int'(rst_out), 0);
    check("glitch cause", int'(rst_cause), 2);
    $display("txn %-22s rst_out=%b ready=%0b cause=%0d", "btn glitch", rst_out, sys_ready, rst_cause);
    #1;
    btn_n = 1'b0;
    wait_rst("btn press", 3'b111, 7);
    check("btn cause", int'(rst_cause), 1);
    repeat (10) @(posedge clk);
    #1;
    check("btn held rst_out", int'(rst_out), 7);
    #1;
    btn_n = 1'b1;
    wait_rst("btn release d0", 3'b110, 12);

    // 4. software request mid-RELEASE
    #1;
    sw_rst_req = 1'b1;
    wait_rst("sw mid-release", 3'b111, 1);
    #1;
    sw_rst_req = 1'b0;
    check("sw cause", int'(rst_cause), 3);
    wait_rst("sw replay d0", 3'b110, 6);
    wait_rst("sw replay done", 3'b000, 4);

    // 5. synced lock loss and sw request on the same cycle
    #1;
    pll_lock = '0;
    repeat (2) @(posedge clk);
    #2;
    sw_rst_req = 1'b1;
    wait_rst("pll+sw", 3'b111, 1);
    #1;
    sw_rst_req = 1'b0;
    pll_lock = '1;
    check("pll+sw cause", int'(rst_cause), 2);
    wait_rst("pll+sw replay d0", 3'b110, 8);
    wait_rst("pll+sw replay done", 3'b000, 4);

    // 6. resetn mid-STRETCH
    #1;
    sw_rst_req = 1'b1;
    wait_rst("sw before resetn", 3'b111, 1);
    #1;
    sw_rst_req = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    resetn = 1'b0;
    #1;
    check("async rst_out", int'(rst_out), 7);
    check("async sys_ready", int'(sys_ready), 0);
    check("async rst_cause", int'(rst_cause), 0);
    $display("txn %-22s rst_out=%b ready=%0b cause=%0d", "resetn mid-stretch", rst_out, sys_ready, rst_cause);
    repeat (3) @(posedge clk);
    #2;
    resetn = 1'b1;
    wait_rst("restart d0", 3'b110, 8);
    wait_rst("restart done", 3'b000, 4);
    check("restart cause", int'(rst_cause), 0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
